// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-meter display path.
package freq_pkg;

  localparam int NUM_DIGITOS = 5;

  typedef logic [4:0] digito_t;

  localparam digito_t CODIGO_APAGADO = 5'd16;
  localparam digito_t CODIGO_TRACO   = 5'd17;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0       = 7'h3f;
  localparam logic [6:0] SEG_1       = 7'h06;
  localparam logic [6:0] SEG_2       = 7'h5b;
  localparam logic [6:0] SEG_3       = 7'h4f;
  localparam logic [6:0] SEG_4       = 7'h66;
  localparam logic [6:0] SEG_5       = 7'h6d;
  localparam logic [6:0] SEG_6       = 7'h7d;
  localparam logic [6:0] SEG_7       = 7'h07;
  localparam logic [6:0] SEG_8       = 7'h7f;
  localparam logic [6:0] SEG_9       = 7'h6f;
  localparam logic [6:0] SEG_TRACO   = 7'h40;
  localparam logic [6:0] SEG_APAGADO = 7'h00;

  typedef enum logic [2:0] {
    SLOT0,
    SLOT1,
    SLOT2,
    SLOT3,
    SLOT4
  } slot_t;

  function automatic slot_t proximo_slot(slot_t s);
    case (s)
      SLOT0:   return SLOT1;
      SLOT1:   return SLOT2;
      SLOT2:   return SLOT3;
      SLOT3:   return SLOT4;
      default: return SLOT0;
    endcase
  endfunction

endpackage

// File: rtl/varredura_display_if.sv
// Result-register side and display-pin side of the scanner, bundled.
interface varredura_display_if;
  import freq_pkg::*;

  logic       habilitar;
  logic       supr_zeros;
  digito_t    digito1;
  digito_t    digito2;
  digito_t    digito3;
  digito_t    digito4;
  digito_t    digito5;
  logic [4:0] ponto;
  logic [4:0] anodo;
  logic [6:0] segmentos;
  logic       dp;
  logic       inicio_quadro;

  modport master (
    output habilitar, supr_zeros, digito1, digito2, digito3, digito4, digito5, ponto,
    input  anodo, segmentos, dp, inicio_quadro
  );

  modport slave (
    input  habilitar, supr_zeros, digito1, digito2, digito3, digito4, digito5, ponto,
    output anodo, segmentos, dp, inicio_quadro
  );

endinterface

// File: rtl/varredura_display_decodificador.sv
// Digit code to active-high 7-segment pattern; unknown codes render blank.
module decodificador_7seg
  import freq_pkg::*;
(
  input  digito_t    codigo,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_APAGADO;
    case (codigo)
      5'd0:         segmentos = SEG_0;
      5'd1:         segmentos = SEG_1;
      5'd2:         segmentos = SEG_2;
      5'd3:         segmentos = SEG_3;
      5'd4:         segmentos = SEG_4;
      5'd5:         segmentos = SEG_5;
      5'd6:         segmentos = SEG_6;
      5'd7:         segmentos = SEG_7;
      5'd8:         segmentos = SEG_8;
      5'd9:         segmentos = SEG_9;
      CODIGO_TRACO: segmentos = SEG_TRACO;
      default:      segmentos = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/varredura_display.sv
// Multiplexes a once-per-frame snapshot of five digit codes onto a
// 5-digit 7-segment display, with anti-ghost blanking and zero suppression.
module varredura_display
  import freq_pkg::*;
#(
  parameter int DIVISOR     = 1000,
  parameter int APAGAR      = 16,
  parameter int ATIVO_BAIXO = 1
) (
  input  logic         clock,
  input  logic         reset,
  varredura_display_if.slave bus
);

  localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0] ULTIMO = PW'(DIVISOR - 1);
  localparam logic [PW-1:0] LIMIAR = PW'(APAGAR);
  localparam logic [4:0] MASC_AN  = (ATIVO_BAIXO != 0) ? 5'b11111 : 5'b00000;
  localparam logic [6:0] MASC_SEG = (ATIVO_BAIXO != 0) ? 7'b1111111 : 7'b0000000;
  localparam logic       MASC_DP  = (ATIVO_BAIXO != 0);

  logic [PW-1:0] prescaler, prescaler_prox;
  slot_t         slot, slot_prox;
  logic          primeiro;
  logic          captura;

  digito_t       sombra [NUM_DIGITOS];
  logic [4:0]    sombra_ponto;
  logic [4:0]    suprimido;
  logic [4:0]    anodo_sel;
  logic          ponto_sel;
  digito_t       codigo_sel;
  logic [6:0]    seg_dec;

  logic [4:0]    anodo_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          inicio_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      slot      <= SLOT0;
      primeiro  <= 1'b1;
    end else begin
      prescaler <= prescaler_prox;
      slot      <= slot_prox;
      if (captura) primeiro <= 1'b0;
    end
  end

  // The first enabled cycle after reset snapshots immediately so the display never waits a frame.
  always_comb begin
    prescaler_prox = prescaler;
    slot_prox      = slot;
    captura        = 1'b0;
    if (bus.habilitar) begin
      captura = primeiro || ((prescaler == ULTIMO) && (slot == SLOT4));
      if (prescaler == ULTIMO) begin
        prescaler_prox = '0;
        slot_prox      = proximo_slot(slot);
      end else begin
        prescaler_prox = prescaler + 1'b1;
      end
    end
  end

  // A digit is a leading zero only if it and every digit above it are 0 with no decimal point.
  always_comb begin
    logic todos_zero;
    suprimido = '0;
    for (int i = 1; i < NUM_DIGITOS; i++) begin
      todos_zero = 1'b1;
      for (int j = i; j < NUM_DIGITOS; j++) begin
        if ((sombra[j] != 5'd0) || sombra_ponto[j]) todos_zero = 1'b0;
      end
      suprimido[i] = bus.supr_zeros && todos_zero;
    end
  end

  always_comb begin
    anodo_sel  = '0;
    ponto_sel  = 1'b0;
    codigo_sel = CODIGO_APAGADO;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (int'(slot) == i) begin
        anodo_sel[i] = 1'b1;
        ponto_sel    = sombra_ponto[i];
        codigo_sel   = suprimido[i] ? CODIGO_APAGADO : sombra[i];
      end
    end
  end

  decodificador_7seg u_decod (
    .codigo    (codigo_sel),
    .segmentos (seg_dec)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITOS; i++) sombra[i] <= CODIGO_APAGADO;
      sombra_ponto <= '0;
      anodo_q      <= MASC_AN;
      seg_q        <= MASC_SEG;
      dp_q         <= MASC_DP;
      inicio_q     <= 1'b0;
    end else begin
      inicio_q <= captura;
      if (captura) begin
        sombra[0]    <= bus.digito1;
        sombra[1]    <= bus.digito2;
        sombra[2]    <= bus.digito3;
        sombra[3]    <= bus.digito4;
        sombra[4]    <= bus.digito5;
        sombra_ponto <= bus.ponto;
      end
      if (bus.habilitar && (prescaler >= LIMIAR)) begin
        anodo_q <= anodo_sel ^ MASC_AN;
        seg_q   <= seg_dec ^ MASC_SEG;
        dp_q    <= ponto_sel ^ MASC_DP;
      end else begin
        anodo_q <= MASC_AN;
        seg_q   <= MASC_SEG;
        dp_q    <= MASC_DP;
      end
    end
  end

  assign bus.anodo         = anodo_q;
  assign bus.segmentos     = seg_q;
  assign bus.dp            = dp_q;
  assign bus.inicio_quadro = inicio_q;

endmodule

// File: tb/tb_varredura_display.sv
// Bench for varredura_display: frame-position reference model checked every cycle,
// plus hand-computed display snapshots at known cycles.
module tb_varredura_display;
  import freq_pkg::*;

  localparam int DIV    = 4;
  localparam int APAG   = 1;
  localparam int QUADRO = 5 * DIV;

  logic clock = 1'b0;
  logic reset;
  int   total  = 0;
  int   falhas = 0;
  int   ciclo  = 0;

  varredura_display_if bus ();

  varredura_display #(
    .DIVISOR     (DIV),
    .APAGAR      (APAG),
    .ATIVO_BAIXO (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: position in the frame is just a count of enabled cycles since reset.
  bit         valido = 1'b0;
  bit         primeiro;
  int         fase;
  digito_t    sh [5];
  logic [4:0] shp;
  logic [4:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_iq;

  function automatic logic [6:0] glifo(int c);
    case (c)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      17:      return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  always @(posedge clock) begin : modelo
    int p, s, topo, cod;
    bit cap;
    ciclo <= ciclo + 1;
    if (reset) begin
      valido   <= 1'b1;
      fase     <= 0;
      primeiro <= 1'b1;
      for (int k = 0; k < 5; k++) sh[k] <= CODIGO_APAGADO;
      shp   <= '0;
      e_an  <= 5'b11111;
      e_seg <= 7'b1111111;
      e_dp  <= 1'b1;
      e_iq  <= 1'b0;
    end else if (valido) begin
      if (bus.habilitar) begin
        p = fase % DIV;
        s = fase / DIV;
        topo = 0;
        for (int k = 1; k < 5; k++) if ((sh[k] != 5'd0) || shp[k]) topo = k;
        if (p < APAG) begin
          e_an  <= 5'b11111;
          e_seg <= 7'b1111111;
          e_dp  <= 1'b1;
        end else begin
          cod = (bus.supr_zeros && (s > topo)) ? 16 : int'(sh[s]);
          e_an  <= ~(5'b00001 << s);
          e_seg <= glifo(cod);
          e_dp  <= ~shp[s];
        end
        cap = primeiro || (fase == QUADRO - 1);
        e_iq <= cap;
        if (cap) begin
          sh[0]    <= bus.digito1;
          sh[1]    <= bus.digito2;
          sh[2]    <= bus.digito3;
          sh[3]    <= bus.digito4;
          sh[4]    <= bus.digito5;
          shp      <= bus.ponto;
          primeiro <= 1'b0;
        end
        fase <= (fase + 1) % QUADRO;
      end else begin
        e_an  <= 5'b11111;
        e_seg <= 7'b1111111;
        e_dp  <= 1'b1;
        e_iq  <= 1'b0;
      end
    end
  end

  task automatic compara(string nome, logic [31:0] obtido, logic [31:0] esperado);
    total++;
    if (obtido !== esperado) begin
      falhas++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", nome, ciclo, obtido, esperado);
    end
  endtask

  always @(negedge clock) begin
    if (valido) begin
      compara("model.anodo", 32'(bus.anodo), 32'(e_an));
      compara("model.segmentos", 32'(bus.segmentos), 32'(e_seg));
      compara("model.dp", 32'(bus.dp), 32'(e_dp));
      compara("model.inicio_quadro", 32'(bus.inicio_quadro), 32'(e_iq));
    end
  end

  task automatic checkOutput(string nome, logic [4:0] an, logic [6:0] seg, logic d, logic iq);
    compara({nome, ".anodo"}, 32'(bus.anodo), 32'(an));
    compara({nome, ".segmentos"}, 32'(bus.segmentos), 32'(seg));
    compara({nome, ".dp"}, 32'(bus.dp), 32'(d));
    compara({nome, ".inicio_quadro"}, 32'(bus.inicio_quadro), 32'(iq));
  endtask

  task automatic applyStimulus(logic h, logic sz, digito_t d5, digito_t d4, digito_t d3,
                               digito_t d2, digito_t d1, logic [4:0] pt);
    bus.habilitar  = h;
    bus.supr_zeros = sz;
    bus.digito5    = d5;
    bus.digito4    = d4;
    bus.digito3    = d3;
    bus.digito2    = d2;
    bus.digito1    = d1;
    bus.ponto      = pt;
  endtask

  task automatic passo(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic digito_t sorteia();
    int r = $urandom_range(0, 9);
    if (r < 4) return 5'd0;
    if (r < 7) return digito_t'($urandom_range(0, 9));
    if (r == 7) return digito_t'($urandom_range(16, 17));
    return digito_t'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      passo(1);
      checkOutput("reset", 5'b11111, 7'b1111111, 1'b1, 1'b0);
    end

    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'b00000);
    passo(1);  checkOutput("first_snapshot", 5'b11111, 7'b1111111, 1'b1, 1'b1);
    passo(1);  checkOutput("slot0_one", 5'b11110, 7'b1111001, 1'b1, 1'b0);
    passo(16); checkOutput("slot4_five", 5'b01111, 7'b0010010, 1'b1, 1'b0);
    passo(2);  checkOutput("second_frame", 5'b01111, 7'b0010010, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'b00000);
    passo(20); checkOutput("old_frame_kept", 5'b01111, 7'b0010010, 1'b1, 1'b1);
    passo(2);  checkOutput("supr_slot0", 5'b11110, 7'b1000000, 1'b1, 1'b0);
    passo(8);  checkOutput("supr_slot2", 5'b11011, 7'b1111000, 1'b1, 1'b0);
    passo(4);  checkOutput("supr_slot3", 5'b10111, 7'b1111111, 1'b1, 1'b0);
    passo(4);  checkOutput("supr_slot4", 5'b01111, 7'b1111111, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'b01000);
    passo(16); checkOutput("dp_keeps_zero", 5'b10111, 7'b1000000, 1'b0, 1'b0);
    passo(4);  checkOutput("dp_slot4_blank", 5'b01111, 7'b1111111, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'b00000);
    passo(4);  checkOutput("reload_slot0", 5'b11110, 7'b1111001, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd8, 5'b00000);
    passo(1);  checkOutput("midframe_hold", 5'b11110, 7'b1111001, 1'b1, 1'b0);
    passo(19); checkOutput("next_frame_8", 5'b11110, 7'b0000000, 1'b1, 1'b0);

    passo(8);
    applyStimulus(1'b0, 1'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd8, 5'b00000);
    passo(1);  checkOutput("paused_dark", 5'b11111, 7'b1111111, 1'b1, 1'b0);
    passo(9);
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd8, 5'b00000);
    passo(1);  checkOutput("resume_slot2", 5'b11011, 7'b0110000, 1'b1, 1'b0);
    passo(3);  checkOutput("resume_slot3", 5'b10111, 7'b0011001, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd5, 5'd4, 5'd25, 5'd17, 5'd16, 5'b00000);
    passo(8);  checkOutput("code16_blank", 5'b11110, 7'b1111111, 1'b1, 1'b0);
    passo(4);  checkOutput("code17_dash", 5'b11101, 7'b0111111, 1'b1, 1'b0);
    passo(4);  checkOutput("code25_blank", 5'b11011, 7'b1111111, 1'b1, 1'b0);
    passo(4);  checkOutput("before_reset", 5'b10111, 7'b0011001, 1'b1, 1'b0);

    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'b00000);
    passo(1);  checkOutput("reset_midframe", 5'b11111, 7'b1111111, 1'b1, 1'b0);
    passo(1);
    reset = 1'b0;
    passo(1);  checkOutput("post_reset_snap", 5'b11111, 7'b1111111, 1'b1, 1'b1);
    passo(1);  checkOutput("post_reset_slot0", 5'b11110, 7'b1111001, 1'b1, 1'b0);

    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      bus.habilitar = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) bus.supr_zeros = ~bus.supr_zeros;
      if ($urandom_range(0, 7) == 0) begin
        bus.digito1 = sorteia();
        bus.digito2 = sorteia();
        bus.digito3 = sorteia();
        bus.digito4 = sorteia();
        bus.digito5 = sorteia();
        bus.ponto   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b00000;
      end
      passo(1);
    end

    reset = 1'b0;
    passo(2);
    $display("End of test - %0d assertions evaluated, %0d failures", total, falhas);
    $finish;
  end

endmodule
